// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared constants and state encoding for the fetch stage slice
package fetch_stage_pkg;
    localparam int PC_W = 32;
    localparam logic [PC_W-1:0] NOP_WORD = 32'h0000_0000;
    localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    typedef enum logic [1:0] {FETCH = 2'd0, HELD = 2'd1, BUBBLE = 2'd2} fetch_state_e;
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: pipeline register with load/hold/flush, flush drops a NOP and keeps pc4
module if_id_reg #(
    parameter int W = 32,
    parameter logic [W-1:0] NOP = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         flush,
    input  logic [W-1:0] instr_d,
    input  logic [W-1:0] pc4_d,
    output logic [W-1:0] instr,
    output logic [W-1:0] pc4,
    output logic         valid
);
    always_ff @(posedge clk) begin
        if (reset) begin
            instr <= NOP;
            pc4   <= '0;
            valid <= 1'b0;
        end else if (load) begin
            instr <= instr_d;
            pc4   <= pc4_d;
            valid <= 1'b1;
        end else if (flush) begin
            instr <= NOP;
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, imem req/ready handshake, one-entry skid buffer and IF/ID register
module fetch_stage #(
    parameter logic [31:0] RESET_PC = fetch_stage_pkg::RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_WORD = fetch_stage_pkg::NOP_WORD
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hz_stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic [31:0] im_rdata,
    input  logic        im_ready,
    output logic [31:0] pc,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid
);
    import fetch_stage_pkg::*;
    fetch_state_e state, state_nxt;
    logic [PC_W-1:0] skid_instr, skid_pc4, pc_inc, pc_nxt, ld_instr, ld_pc4;
    logic xfer, load, flush, in_fetch, in_held;
    assign im_req  = (state == FETCH) && !reset;
    assign im_addr = pc;
    always_comb begin
        in_fetch  = state == FETCH;
        in_held   = state == HELD;
        xfer      = im_req && im_ready;
        pc_inc    = pc + 32'd4;
        load      = !br_taken && !hz_stall && ((in_fetch && xfer) || in_held);
        flush     = br_taken || (!hz_stall && ((in_fetch && !xfer) || state == BUBBLE));
        ld_instr  = in_held ? skid_instr : im_rdata;
        ld_pc4    = in_held ? skid_pc4 : pc_inc;
        pc_nxt    = br_taken ? {br_target[31:2], 2'b00} : xfer ? pc_inc : pc;
        state_nxt = br_taken ? BUBBLE :
                    (in_fetch && xfer && hz_stall) ? HELD :
                    (in_held && hz_stall) ? HELD : FETCH;
    end
    // skid is written only from FETCH, so a full buffer can never be overwritten
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            skid_instr <= '0;
            skid_pc4   <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (br_taken || (in_held && !hz_stall)) begin
                skid_instr <= '0;
                skid_pc4   <= '0;
            end else if (in_fetch && xfer && hz_stall) begin
                skid_instr <= im_rdata;
                skid_pc4   <= pc_inc;
            end
        end
    end
    if_id_reg #(.W(PC_W), .NOP(NOP_WORD)) u_if_id (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .flush   (flush),
        .instr_d (ld_instr),
        .pc4_d   (ld_pc4),
        .instr   (if_id_instr),
        .pc4     (if_id_pc4),
        .valid   (if_id_valid)
    );
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vectors with a per-cycle expectation queue checked by a monitor
module tb_fetch_stage;
    logic clk = 1'b0;
    logic reset, hz_stall, br_taken, im_ready, im_req, if_id_valid;
    logic [31:0] br_target, im_rdata, im_addr, pc, if_id_instr, if_id_pc4;
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic [31:0] pc;
        logic        req;
    } exp_t;
    exp_t q[$];
    int checks = 0;
    int fails = 0;
    fetch_stage dut (
        .clk         (clk),
        .reset       (reset),
        .hz_stall    (hz_stall),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .im_req      (im_req),
        .im_addr     (im_addr),
        .im_rdata    (im_rdata),
        .im_ready    (im_ready),
        .pc          (pc),
        .if_id_instr (if_id_instr),
        .if_id_pc4   (if_id_pc4),
        .if_id_valid (if_id_valid)
    );
    always #5 clk = ~clk;
    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("if_id_instr", if_id_instr, e.instr);
            chk("if_id_pc4", if_id_pc4, e.pc4);
            chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, e.valid});
            chk("pc", pc, e.pc);
            chk("im_addr", im_addr, e.pc);
            chk("im_req", {31'd0, im_req}, {31'd0, e.req});
        end
    end
    task automatic step(input logic r, input logic s, input logic b, input logic [31:0] t,
                        input logic rd, input logic [31:0] d,
                        input logic [31:0] ei, input logic [31:0] ep4, input logic ev,
                        input logic [31:0] epc, input logic ereq);
        exp_t e;
        @(negedge clk);
        reset = r; hz_stall = s; br_taken = b; br_target = t; im_ready = rd; im_rdata = d;
        e.instr = ei; e.pc4 = ep4; e.valid = ev; e.pc = epc; e.req = ereq;
        q.push_back(e);
    endtask
    initial begin
        reset = 1'b1; hz_stall = 1'b0; br_taken = 1'b0; br_target = '0; im_ready = 1'b0; im_rdata = '0;
        //    rst stl br  target        rdy rdata         instr         pc4           v  pc            req
        step(1, 0, 0, 32'h0,        0, 32'h0,        32'h0,        32'h0,        0, 32'h0,        0);
        step(1, 0, 0, 32'h0,        1, 32'h1234,     32'h0,        32'h0,        0, 32'h0,        0);
        step(0, 0, 0, 32'h0,        1, 32'hE3A01005, 32'hE3A01005, 32'h4,        1, 32'h4,        1);
        step(0, 0, 0, 32'h0,        1, 32'hE3A02003, 32'hE3A02003, 32'h8,        1, 32'h8,        1);
        step(0, 0, 0, 32'h0,        0, 32'hFFFFFFFF, 32'h0,        32'h8,        0, 32'h8,        1);
        step(0, 0, 0, 32'h0,        0, 32'hFFFFFFFF, 32'h0,        32'h8,        0, 32'h8,        1);
        step(0, 0, 0, 32'h0,        1, 32'h11111111, 32'h11111111, 32'hC,        1, 32'hC,        1);
        step(0, 1, 0, 32'h0,        1, 32'hE5910000, 32'h11111111, 32'hC,        1, 32'h10,       0);
        step(0, 1, 0, 32'h0,        1, 32'hDEADBEEF, 32'h11111111, 32'hC,        1, 32'h10,       0);
        step(0, 0, 0, 32'h0,        1, 32'hDEADBEEF, 32'hE5910000, 32'h10,       1, 32'h10,       1);
        step(0, 0, 1, 32'h40,       1, 32'hAAAAAAAA, 32'h0,        32'h10,       0, 32'h40,       0);
        step(0, 0, 0, 32'h0,        1, 32'hBBBBBBBB, 32'h0,        32'h10,       0, 32'h40,       1);
        step(0, 0, 0, 32'h0,        1, 32'h12345678, 32'h12345678, 32'h44,       1, 32'h44,       1);
        step(0, 1, 0, 32'h0,        1, 32'hCAFEBABE, 32'h12345678, 32'h44,       1, 32'h48,       0);
        step(0, 1, 1, 32'h103,      1, 32'h99999999, 32'h0,        32'h44,       0, 32'h100,      0);
        step(0, 1, 0, 32'h0,        1, 32'h99999999, 32'h0,        32'h44,       0, 32'h100,      1);
        step(0, 0, 0, 32'h0,        1, 32'h0F0F0F0F, 32'h0F0F0F0F, 32'h104,      1, 32'h104,      1);
        step(0, 1, 0, 32'h0,        1, 32'h77777777, 32'h0F0F0F0F, 32'h104,      1, 32'h108,      0);
        step(1, 1, 0, 32'h0,        1, 32'h77777777, 32'h0,        32'h0,        0, 32'h0,        0);
        step(0, 0, 0, 32'h0,        0, 32'h77777777, 32'h0,        32'h0,        0, 32'h0,        1);
        step(0, 0, 1, 32'hFFFFFFFC, 1, 32'h66666666, 32'h0,        32'h0,        0, 32'hFFFFFFFC, 0);
        step(0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        32'h0,        0, 32'hFFFFFFFC, 1);
        step(0, 0, 0, 32'h0,        1, 32'h55AA55AA, 32'h55AA55AA, 32'h0,        1, 32'h0,        1);
        step(0, 1, 0, 32'h0,        0, 32'h0,        32'h55AA55AA, 32'h0,        1, 32'h0,        1);
        @(posedge clk);
        #2;
        chk("queue_drained", q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
